count_wrap_monitor: RTL and testbench
=====================================

// Module: count_wrap_monitor
// PURPOSE
//   Sits directly downstream of the 4-bit free-running counter and consumes its count bus.
//   Checks that the count advances by exactly +1 every clock.
//   Extends the count with an epoch (wrap) counter.
//   Queues one record per wrap or resync event into a small FIFO, read by a valid/ready consumer.
// PARAMETERS
//   CW     4  width of the monitored count bus
//   EW     8  epoch counter width; record width is EW+1
//   DEPTH  4  record FIFO depth (power of two, >=2)
// PORTS
//   clk        in   1            rising-edge clock, shared with the counter
//   reset      in   1            asynchronous, active-low reset
//   count      in   CW           counter value, registered upstream on the same clk
//   clr_err    in   1            synchronous clear of the step_err and ovf sticky flags
//   out_ready  in   1            consumer accepts the head record this cycle
//   out_valid  out  1            FIFO non-empty
//   out_data   out  EW+1         head record: {resync_bit, epoch[EW-1:0]}
//   epoch      out  EW           current wrap count
//   step_err   out  1            sticky: a non +1 step was seen
//   ovf        out  1            sticky: a record was dropped because the FIFO was full
//   level      out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//   Reset (async, while reset==0):
//     - outputs: out_valid=0, out_data=0, epoch=0, step_err=0, ovf=0, level=0
//     - state: state=S_PRIME, prev=0, FIFO emptied
//   prev register: captures count on every clock edge after reset.
//   FSM, evaluated per edge on the sampled count:
//     S_PRIME: no checks; next state S_TRACK.
//     S_TRACK: expected value is count == prev+1 (mod 2^CW).
//       - wrap (prev==2^CW-1 and count==0): epoch<=epoch+1, mod 2^EW, no flag on epoch rollover; push {0,epoch+1}.
//       - mismatch, including a held value: step_err<=1, no push; next state S_FAULT.
//     S_FAULT: stays until a sampled count==0.
//       - on count==0: push {1,epoch} with epoch unchanged; next state S_TRACK.
//   Latency: the counter shows 0 after edge k; the monitor samples it at edge k+1.
//     The record, epoch and out_valid update after edge k+1.
//   FIFO:
//     - pop when out_valid && out_ready; out_data is the registered head entry.
//     - push when full with no pop: record dropped, ovf<=1.
//     - push when full with a pop in the same cycle: push accepted, level unchanged.
//     - push when empty: record visible on the next cycle. No bypass path.
//   clr_err: clears both sticky flags. If a set event occurs in the same cycle, set wins.
//   Reset asserted mid-operation: every register clears immediately and queued records are lost.
//     The first edge after release re-enters S_PRIME, so no false step_err is raised.
// STRUCTURE
//   - Header cwm_defs.vh: state encodings S_PRIME=2'd0, S_TRACK=2'd1, S_FAULT=2'd2.
//     Also holds the record field positions RESYNC_BIT=EW.
//   - Sub-module sync_fifo #(WIDTH=EW+1, DEPTH): push, pop, full, empty, level.
//     It uses the same clk and reset.
//   - The top level holds prev, the FSM, the epoch counter and the sticky flags.
// TESTING
//   1. Reset low 15ns, then high; counter free-running; out_ready=1.
//      -> first 15->0 gives out_data=9'h001, epoch=1; then epoch +1 every 16 cycles; step_err=0.
//   2. out_ready=0 across 5 wraps.
//      -> level=4, ovf=1 after the 5th; draining yields 9'h001, 9'h002, 9'h003, 9'h004, then out_valid=0.
//   3. At epoch=2, force count to jump 5->9.
//      -> step_err=1, no record at the next 15->0; on count==0 record 9'h102; next wrap 9'h003.
//   4. Run 256 wraps with out_ready=1.
//      -> the 256th record is 9'h000, epoch=0, and no flag is raised.
//   5. clr_err pulse alone -> step_err=0 and ovf=0 next cycle.
//      clr_err in the same cycle as a new jump -> step_err stays 1.
//   6. Drop reset for 3ns while level=2.
//      -> out_valid=0 and epoch=0 immediately; after release, the first edge raises no step_err.
//      -> the next wrap gives 9'h001.

Source files
------------

// File: rtl/count_wrap_monitor_pkg.sv
// Shared definitions for the count wrap monitor.
//   state_e  : monitor FSM states (prime, track, fault)
//   CWM_*    : default widths/depth used by the top level
package count_wrap_monitor_pkg;

  typedef enum logic [1:0] {
    S_PRIME = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  localparam int unsigned CWM_CW    = 4;
  localparam int unsigned CWM_EW    = 8;
  localparam int unsigned CWM_DEPTH = 4;

endpackage

// File: rtl/count_wrap_monitor_sync_fifo.sv
// Synchronous FIFO holding monitor records.
//   clk, reset : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   dout       : registered head entry
//   full/empty : occupancy flags
//   level      : number of stored entries
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == LW'(DEPTH));
  assign level = cnt_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/count_wrap_monitor.sv
// Monitor for a free-running CW-bit counter.
//   clk, reset : clock shared with the counter, asynchronous active-low reset
//   count      : counter value, registered upstream on clk
//   clr_err    : synchronous clear of step_err and ovf (a same-cycle set wins)
//   out_ready  : consumer accepts the head record
//   out_valid  : record FIFO non-empty
//   out_data   : head record {resync_bit, epoch}
//   epoch      : wrap count
//   step_err   : sticky, a non +1 step was observed
//   ovf        : sticky, a record was dropped on a full FIFO
//   level      : FIFO occupancy
module count_wrap_monitor
  import count_wrap_monitor_pkg::*;
#(
  parameter int unsigned CW    = CWM_CW,
  parameter int unsigned EW    = CWM_EW,
  parameter int unsigned DEPTH = CWM_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CW-1:0]          count,
  input  logic                   clr_err,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [EW:0]            out_data,
  output logic [EW-1:0]          epoch,
  output logic                   step_err,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] level
);

  state_e        state_q, state_d;
  logic [CW-1:0] prev_q, prev_d;
  logic [EW-1:0] epoch_q, epoch_d;
  logic          step_err_q, step_err_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] prev_inc;
  logic          push, pop, full, empty, step_set, drop;
  logic [EW:0]   rec;

  assign prev_inc = prev_q + 1'b1;

  // Wrap is the +1 step that lands on zero; a resync record carries the unchanged epoch.
  always_comb begin
    state_d  = state_q;
    prev_d   = count;
    epoch_d  = epoch_q;
    push     = 1'b0;
    rec      = '0;
    step_set = 1'b0;
    case (state_q)
      S_PRIME: state_d = S_TRACK;
      S_TRACK: begin
        if (count == prev_inc) begin
          if (count == '0) begin
            epoch_d = epoch_q + 1'b1;
            push    = 1'b1;
            rec     = {1'b0, epoch_d};
          end
        end else begin
          step_set = 1'b1;
          state_d  = S_FAULT;
        end
      end
      S_FAULT: begin
        if (count == '0) begin
          push    = 1'b1;
          rec     = {1'b1, epoch_q};
          state_d = S_TRACK;
        end
      end
      default: state_d = S_PRIME;
    endcase
  end

  assign pop        = out_valid && out_ready;
  assign drop       = push && full && !pop;
  assign step_err_d = step_set | (step_err_q & ~clr_err);
  assign ovf_d      = drop | (ovf_q & ~clr_err);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_PRIME;
      prev_q     <= '0;
      epoch_q    <= '0;
      step_err_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      epoch_q    <= epoch_d;
      step_err_q <= step_err_d;
      ovf_q      <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (EW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (rec),
    .pop   (pop),
    .dout  (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign out_valid = !empty;
  assign epoch     = epoch_q;
  assign step_err  = step_err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_count_wrap_monitor.sv
module tb_count_wrap_monitor;

  localparam int CW    = 4;
  localparam int EW    = 8;
  localparam int DEPTH = 4;
  localparam int CMOD  = 1 << CW;
  localparam int EMOD  = 1 << EW;

  logic          clk = 1'b1;
  logic          reset;
  logic [CW-1:0] count;
  logic          clr_err;
  logic          out_ready;
  logic          out_valid;
  logic [EW:0]   out_data;
  logic [EW-1:0] epoch;
  logic          step_err;
  logic          ovf;
  logic [2:0]    level;

  always #5 clk = ~clk;

  count_wrap_monitor #(.CW(CW), .EW(EW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .clr_err   (clr_err),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .epoch     (epoch),
    .step_err  (step_err),
    .ovf       (ovf),
    .level     (level)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: counter history as integers, records in a queue.
  int m_prev, m_epoch;
  bit m_primed, m_fault, m_err, m_ovf;
  int m_q[$];

  function automatic void m_reset();
    m_prev = 0; m_epoch = 0; m_primed = 0; m_fault = 0;
    m_err = 0; m_ovf = 0; m_q.delete();
  endfunction

  function automatic void m_step(int c, bit clr, bit rdy);
    bit popv = (m_q.size() > 0) && rdy;
    int rec  = -1;
    bit eset = 0, drop = 0;
    if (!m_primed) m_primed = 1;
    else if (!m_fault) begin
      if (c == (m_prev + 1) % CMOD) begin
        if (c == 0) begin
          m_epoch = (m_epoch + 1) % EMOD;
          rec = m_epoch;
        end
      end else begin
        eset = 1; m_fault = 1;
      end
    end else if (c == 0) begin
      rec = EMOD + m_epoch; m_fault = 0;
    end
    m_prev = c;
    if (popv) void'(m_q.pop_front());
    if (rec >= 0) begin
      if (m_q.size() < DEPTH) m_q.push_back(rec);
      else drop = 1;
    end
    m_err = eset || (m_err && !clr);
    m_ovf = drop || (m_ovf && !clr);
  endfunction

  task automatic cmp_model(input string tag);
    check({tag, "_valid"}, out_valid, m_q.size() != 0);
    check({tag, "_level"}, level, m_q.size());
    check({tag, "_epoch"}, epoch, m_epoch);
    check({tag, "_step_err"}, step_err, m_err);
    check({tag, "_ovf"}, ovf, m_ovf);
    if (m_q.size() > 0) check({tag, "_data"}, out_data, m_q[0]);
  endtask

  // Called at a negedge: drive, let one posedge pass, compare at the next negedge.
  task automatic tick(input int c, input bit clr, input bit rdy);
    count = c[CW-1:0]; clr_err = clr; out_ready = rdy;
    @(posedge clk);
    m_step(c, clr, rdy);
    @(negedge clk);
    cmp_model("model");
  endtask

  int ctr;

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      tick(ctr, 1'b0, rdy);
      ctr = (ctr + 1) % CMOD;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rst_valid"}, out_valid, 0);
    check({tag, "_rst_data"}, out_data, 0);
    check({tag, "_rst_epoch"}, epoch, 0);
    check({tag, "_rst_err"}, step_err, 0);
    check({tag, "_rst_ovf"}, ovf, 0);
    check({tag, "_rst_level"}, level, 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0; count = '0; clr_err = 1'b0;
    m_reset();
    #10;
    check_reset_vals(tag);
    reset = 1'b1;
    ctr = 0;
  endtask

  // Short async reset pulse between edges; the counter keeps running.
  task automatic async_pulse(input string tag);
    #1 reset = 1'b0;
    #1;
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_epoch"}, epoch, 0);
    check({tag, "_level"}, level, 0);
    m_reset();
    #2 reset = 1'b1;
  endtask

  typedef struct {
    logic [3:0] c;
    logic       clr;
    logic       rdy;
    logic       v;
    logic [8:0] d;
    logic [7:0] e;
    logic       err;
    logic [2:0] lvl;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{4'd14, 1'b0, 1'b0, 1'b0, 9'h000, 8'd0, 1'b0, 3'd0};
    tbl[1]  = '{4'd15, 1'b0, 1'b0, 1'b0, 9'h000, 8'd0, 1'b0, 3'd0};
    tbl[2]  = '{4'd0,  1'b0, 1'b0, 1'b1, 9'h001, 8'd1, 1'b0, 3'd1};
    tbl[3]  = '{4'd1,  1'b0, 1'b0, 1'b1, 9'h001, 8'd1, 1'b0, 3'd1};
    tbl[4]  = '{4'd3,  1'b0, 1'b1, 1'b0, 9'h000, 8'd1, 1'b1, 3'd0};
    tbl[5]  = '{4'd7,  1'b1, 1'b0, 1'b0, 9'h000, 8'd1, 1'b0, 3'd0};
    tbl[6]  = '{4'd0,  1'b0, 1'b0, 1'b1, 9'h101, 8'd1, 1'b0, 3'd1};
    tbl[7]  = '{4'd1,  1'b0, 1'b0, 1'b1, 9'h101, 8'd1, 1'b0, 3'd1};
    tbl[8]  = '{4'd2,  1'b1, 1'b1, 1'b0, 9'h000, 8'd1, 1'b0, 3'd0};
    tbl[9]  = '{4'd2,  1'b1, 1'b0, 1'b0, 9'h000, 8'd1, 1'b1, 3'd0};
    tbl[10] = '{4'd0,  1'b0, 1'b0, 1'b1, 9'h101, 8'd1, 1'b1, 3'd1};
    tbl[11] = '{4'd1,  1'b0, 1'b0, 1'b1, 9'h101, 8'd1, 1'b1, 3'd1};

    // Free-running counter from reset, consumer always ready.
    reset = 1'b0; count = '0; clr_err = 1'b0; out_ready = 1'b1;
    m_reset();
    #14;
    check_reset_vals("t1");
    #1 reset = 1'b1;
    ctr = 0;
    run(17, 1'b1);
    check("t1_first_data", out_data, 9'h001);
    check("t1_first_epoch", epoch, 1);
    run(16, 1'b1);
    check("t1_second_data", out_data, 9'h002);
    check("t1_second_epoch", epoch, 2);
    check("t1_err", step_err, 0);

    // Table of vectors from a fresh reset.
    do_reset("tbl");
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].c, tbl[i].clr, tbl[i].rdy);
      check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].v);
      check($sformatf("tbl%0d_epoch", i), epoch, tbl[i].e);
      check($sformatf("tbl%0d_err", i), step_err, tbl[i].err);
      check($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
      check($sformatf("tbl%0d_ovf", i), ovf, 0);
      if (tbl[i].v) check($sformatf("tbl%0d_data", i), out_data, tbl[i].d);
    end

    // Five wraps with the consumer stalled, then drain.
    do_reset("t2");
    run(81, 1'b0);
    check("t2_level", level, 4);
    check("t2_ovf", ovf, 1);
    check("t2_epoch", epoch, 5);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t2_drain%0d_valid", i), out_valid, 1);
      check($sformatf("t2_drain%0d_data", i), out_data, i);
      run(1, 1'b1);
    end
    check("t2_empty", out_valid, 0);

    // Jump 5->9 at epoch 2, resync at the next zero.
    do_reset("t3");
    run(33, 1'b1);
    run(5, 1'b1);
    ctr = 9;
    run(1, 1'b1);
    check("t3_err", step_err, 1);
    run(6, 1'b1);
    run(1, 1'b1);
    check("t3_resync_valid", out_valid, 1);
    check("t3_resync_data", out_data, 9'h102);
    check("t3_resync_epoch", epoch, 2);
    run(16, 1'b1);
    check("t3_wrap_data", out_data, 9'h003);
    check("t3_wrap_epoch", epoch, 3);

    // Epoch rollover after 256 wraps.
    do_reset("t4");
    run(1 + 256 * 16, 1'b1);
    check("t4_valid", out_valid, 1);
    check("t4_data", out_data, 9'h000);
    check("t4_epoch", epoch, 0);
    check("t4_err", step_err, 0);
    check("t4_ovf", ovf, 0);

    // Sticky clear alone, then clear colliding with a new jump.
    do_reset("t5");
    run(81, 1'b0);
    check("t5_ovf_set", ovf, 1);
    tick(5, 1'b0, 1'b1);
    check("t5_err_set", step_err, 1);
    tick(6, 1'b1, 1'b1);
    check("t5_err_clr", step_err, 0);
    check("t5_ovf_clr", ovf, 0);
    tick(0, 1'b0, 1'b1);
    tick(1, 1'b0, 1'b1);
    tick(7, 1'b1, 1'b1);
    check("t5_set_wins", step_err, 1);
    check("t5_ovf_stays_clr", ovf, 0);

    // Short reset pulse with two records queued.
    do_reset("t6");
    run(33, 1'b0);
    check("t6_level_before", level, 2);
    async_pulse("t6_pulse");
    run(1, 1'b1);
    check("t6_no_false_err", step_err, 0);
    run(15, 1'b1);
    check("t6_wrap_valid", out_valid, 1);
    check("t6_wrap_data", out_data, 9'h001);
    check("t6_wrap_epoch", epoch, 1);

    // Randomized traffic against the model.
    do_reset("rnd");
    begin
      int rdy_pct = 70;
      for (int i = 0; i < 3000; i++) begin
        int c;
        bit clr, rdy;
        if (i % 200 == 0) rdy_pct = $urandom_range(0, 100);
        if (i == 1500) async_pulse("rnd_pulse");
        c   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, CMOD - 1)) : ctr;
        clr = ($urandom_range(0, 15) == 0);
        rdy = ($urandom_range(0, 99) < rdy_pct);
        tick(c, clr, rdy);
        ctr = (c + 1) % CMOD;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
